// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation for load-use, branch, jump, multiply/divide and halt.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_jump,
    input  logic [4:0] ex_rd_w,
    input  logic       ex_regfile_w_en,
    input  logic       ex_is_load,
    input  logic       ex_branch_taken,
    input  logic       ex_md_start,
    input  logic       mem_wait,
    input  logic       wb_halt,
    output logic       pc_en,
    output logic       en_ps1,
    output logic       en_ps2,
    output logic       en_ps3,
    output logic       en_ps4,
    output logic       clear_ps1,
    output logic       clear_ps2,
    output logic       clear_ps3,
    output logic       clear_ps4,
    output logic       md_done,
    output logic       halted
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {RUN, MDWAIT, HALTED} state_t;

    localparam logic [3:0] MD_LOAD = 4'(MD_LAT - 1);

    state_t     state, state_nx;
    logic [3:0] md_cnt, md_cnt_nx;
    logic       md_resume, md_resume_nx;
    logic       load_use;
    logic       md_start_eff;

    assign load_use = ex_is_load & ex_regfile_w_en & (ex_rd_w != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_rd_w)) | (id_uses_rt & (id_rt == ex_rd_w)));

    // The MD instruction is still in EX on the first cycle after MDWAIT; do not restart it.
    assign md_start_eff = ex_md_start & ~md_resume;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            md_cnt    <= '0;
            md_resume <= 1'b0;
        end else begin
            state     <= state_nx;
            md_cnt    <= md_cnt_nx;
            md_resume <= md_resume_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        md_cnt_nx    = md_cnt;
        md_resume_nx = md_resume;
        case (state)
            RUN: begin
                if (!mem_wait) begin
                    md_resume_nx = 1'b0;
                    if (md_start_eff) begin
                        state_nx  = MDWAIT;
                        md_cnt_nx = MD_LOAD;
                    end
                end
            end
            MDWAIT: begin
                if (!mem_wait) begin
                    if (md_cnt == 4'd1) begin
                        state_nx     = RUN;
                        md_cnt_nx    = '0;
                        md_resume_nx = 1'b1;
                    end else begin
                        md_cnt_nx = md_cnt - 4'd1;
                    end
                end
            end
            HALTED: ;
            default: state_nx = RUN;
        endcase
        if (wb_halt) state_nx = HALTED;
    end

    always_comb begin
        pc_en     = 1'b1;
        en_ps1    = 1'b1;
        en_ps2    = 1'b1;
        en_ps3    = 1'b1;
        en_ps4    = 1'b1;
        clear_ps1 = 1'b0;
        clear_ps2 = 1'b0;
        clear_ps3 = 1'b0;
        clear_ps4 = 1'b0;
        md_done   = 1'b0;
        if (!rst_n) begin
            pc_en     = 1'b0;
            en_ps1    = 1'b0;
            en_ps2    = 1'b0;
            en_ps3    = 1'b0;
            en_ps4    = 1'b0;
            clear_ps1 = 1'b1;
            clear_ps2 = 1'b1;
            clear_ps3 = 1'b1;
            clear_ps4 = 1'b1;
        end else if (state == HALTED || mem_wait) begin
            pc_en  = 1'b0;
            en_ps1 = 1'b0;
            en_ps2 = 1'b0;
            en_ps3 = 1'b0;
            en_ps4 = 1'b0;
        end else if (state == MDWAIT || (state == RUN && md_start_eff)) begin
            pc_en     = 1'b0;
            en_ps1    = 1'b0;
            en_ps2    = 1'b0;
            en_ps3    = 1'b0;
            clear_ps3 = 1'b1;
            md_done   = (state == MDWAIT) && (md_cnt == 4'd1);
        end else if (ex_branch_taken) begin
            clear_ps1 = 1'b1;
            clear_ps2 = 1'b1;
        end else if (load_use) begin
            pc_en     = 1'b0;
            en_ps1    = 1'b0;
            clear_ps2 = 1'b1;
        end else if (id_jump) begin
            clear_ps1 = 1'b1;
        end
    end

    assign halted = (state == HALTED);

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!pc_en && state != HALTED && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
            if (clear_ps1 && flush_count != '1)
                flush_count <= flush_count + 32'd1;
        end
    end
`endif

endmodule
